// File: rtl/register_file_param.sv
// Multi-port register file with write-to-read bypass, optional hardwired zero register and sequenced bulk clear.
// Latency: reads combinational (REG_READ=0) or one cycle (REG_READ=1); writes land on the next rising edge.
// Backpressure: busy is high for DEPTH cycles during a bulk clear; writes issued then are dropped and reads return 0.
module register_file_param #(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_LENGTH = 5,
    parameter int NUM_READ    = 2,
    parameter int REG_READ    = 0,
    parameter int ZERO_REG    = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            write,
    input  logic [ADDR_LENGTH-1:0]          Write_register,
    input  logic [WORD_LENGTH-1:0]          Write_data,
    input  logic [NUM_READ*ADDR_LENGTH-1:0] Read_reg,
    output logic [NUM_READ*WORD_LENGTH-1:0] Read_data,
    input  logic                            clear_req,
    output logic                            busy
);

    localparam int DEPTH = 2 ** ADDR_LENGTH;

    generate
        if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
            $error("register_file_param: NUM_READ must be in 1..4");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                 state;
    logic [ADDR_LENGTH-1:0] clr_cnt;
    logic [WORD_LENGTH-1:0] regs [DEPTH];
    logic                   wr_en;

    // Register 0 is never written when it is hardwired to zero.
    assign wr_en = write && !busy && !((ZERO_REG != 0) && (Write_register == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            state   <= IDLE;
            clr_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        regs[Write_register] <= Write_data;
                    end
                    if (clear_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    regs[clr_cnt] <= '0;
                    clr_cnt       <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar p = 0; p < NUM_READ; p++) begin : g_port
            logic [ADDR_LENGTH-1:0] sel;
            logic [WORD_LENGTH-1:0] val;

            assign sel = Read_reg[p*ADDR_LENGTH +: ADDR_LENGTH];

            always_comb begin
                val = regs[sel];
                if (busy) begin
                    val = '0;
                end else if ((ZERO_REG != 0) && (sel == '0)) begin
                    val = '0;
                end else if (write && (Write_register == sel)) begin
                    val = Write_data;
                end
            end

            if (REG_READ != 0) begin : g_reg
                logic [WORD_LENGTH-1:0] rd_q;
                always_ff @(posedge clk) begin
                    if (reset) begin
                        rd_q <= '0;
                    end else begin
                        rd_q <= val;
                    end
                end
                assign Read_data[p*WORD_LENGTH +: WORD_LENGTH] = rd_q;
            end else begin : g_comb
                assign Read_data[p*WORD_LENGTH +: WORD_LENGTH] = val;
            end
        end
    endgenerate

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: three configurations (default, ZERO_REG=0, REG_READ=1) share one stimulus stream.
module tb_register_file_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write_i = 1'b0;
    logic [4:0]  wsel = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  sel0 = '0;
    logic [4:0]  sel1 = '0;
    logic        clear_req = 1'b0;
    logic [9:0]  read_reg;
    logic [63:0] rd_a, rd_b, rd_c;
    logic        busy_a, busy_b, busy_c;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: stored contents, reg 0 of the ZERO_REG=0 copy, clear engine state.
    logic [31:0] mem [32];
    logic [31:0] z0_m;
    bit          busy_m;
    int          cnt_m;
    logic [31:0] rr_exp [2];

    assign read_reg = {sel1, sel0};

    always #5 clk = ~clk;

    register_file_param dut_a (
        .clk(clk), .reset(reset), .write(write_i), .Write_register(wsel), .Write_data(wdata),
        .Read_reg(read_reg), .Read_data(rd_a), .clear_req(clear_req), .busy(busy_a)
    );

    register_file_param #(.ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .write(write_i), .Write_register(wsel), .Write_data(wdata),
        .Read_reg(read_reg), .Read_data(rd_b), .clear_req(clear_req), .busy(busy_b)
    );

    register_file_param #(.REG_READ(1)) dut_c (
        .clk(clk), .reset(reset), .write(write_i), .Write_register(wsel), .Write_data(wdata),
        .Read_reg(read_reg), .Read_data(rd_c), .clear_req(clear_req), .busy(busy_c)
    );

    function automatic logic [31:0] exp_read(input logic [4:0] s, input bit zr);
        if (busy_m) return 32'h0;
        if (zr && s == 5'd0) return 32'h0;
        if (write_i && wsel == s) return wdata;
        if (s == 5'd0) return z0_m;
        return mem[s];
    endfunction

    // One rising edge; the model advances using the inputs that were stable before it.
    task automatic tick();
        logic [31:0] nxt0, nxt1;
        nxt0 = reset ? 32'h0 : exp_read(sel0, 1'b1);
        nxt1 = reset ? 32'h0 : exp_read(sel1, 1'b1);
        @(posedge clk);
        rr_exp[0] = nxt0;
        rr_exp[1] = nxt1;
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            z0_m = 32'h0;
            busy_m = 1'b0;
            cnt_m = 0;
        end else if (busy_m) begin
            if (cnt_m == 0) z0_m = 32'h0;
            mem[cnt_m] = 32'h0;
            cnt_m++;
            if (cnt_m == 32) begin
                busy_m = 1'b0;
                cnt_m = 0;
            end
        end else begin
            if (write_i) begin
                if (wsel == 5'd0) z0_m = wdata;
                else mem[wsel] = wdata;
            end
            if (clear_req) begin
                busy_m = 1'b1;
                cnt_m = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            write_i = 1'b1;
            wsel = 5'($urandom);
            wdata = $urandom;
            tick();
        end
        write_i = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || busy_c !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got %b%b%b want 000", busy_a, busy_b, busy_c);
        end
        for (int s = 0; s < 32; s++) begin
            sel0 = 5'(s);
            sel1 = 5'(31 - s);
            #1;
            vectors++;
            if (rd_a !== 64'h0 || rd_b !== 64'h0 || rd_c !== 64'h0) begin
                miscompares++;
                $display("FAIL reset_read sel=%0d got a=%h b=%h c=%h want 0", s, rd_a, rd_b, rd_c);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        write_i = 1'b1;
        wsel = 5'd5;
        wdata = 32'hDEADBEEF;
        sel0 = 5'd0;
        sel1 = 5'd5;
        #1;
        vectors++;
        if (rd_a[63:32] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL bypass_same_cycle got %h want deadbeef", rd_a[63:32]);
        end
        tick();
        vectors++;
        if (rd_c[63:32] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL bypass_registered got %h want deadbeef", rd_c[63:32]);
        end
        write_i = 1'b0;
        sel0 = 5'd5;
        #1;
        vectors++;
        if (rd_a[31:0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL stored_read got %h want deadbeef", rd_a[31:0]);
        end
    endtask

    task automatic test_zero_reg();
        write_i = 1'b1;
        wsel = 5'd0;
        wdata = 32'hFFFFFFFF;
        sel0 = 5'd0;
        sel1 = 5'd0;
        #1;
        vectors++;
        if (rd_a !== 64'h0 || rd_b !== {2{32'hFFFFFFFF}}) begin
            miscompares++;
            $display("FAIL zero_reg_bypass got a=%h b=%h want a=0 b=all-ones", rd_a, rd_b);
        end
        tick();
        write_i = 1'b0;
        #1;
        vectors++;
        if (rd_a !== 64'h0 || rd_b !== {2{32'hFFFFFFFF}} || rd_c !== 64'h0) begin
            miscompares++;
            $display("FAIL zero_reg_stored got a=%h b=%h c=%h want a=0 b=all-ones c=0", rd_a, rd_b, rd_c);
        end
    endtask

    task automatic test_clear();
        int n;
        for (int i = 1; i < 32; i++) begin
            write_i = 1'b1;
            wsel = 5'(i);
            wdata = 32'(i);
            tick();
        end
        write_i = 1'b0;
        sel0 = 5'd17;
        #1;
        vectors++;
        if (rd_a[31:0] !== 32'd17) begin
            miscompares++;
            $display("FAIL fill_read got %h want 00000011", rd_a[31:0]);
        end
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            write_i = 1'b1;
            wsel = 5'($urandom_range(1, 31));
            wdata = $urandom | 32'h1;
            clear_req = ($urandom % 4 == 0);
            n++;
            tick();
        end
        write_i = 1'b0;
        clear_req = 1'b0;
        vectors++;
        if (n != 32) begin
            miscompares++;
            $display("FAIL clear_busy_cycles got %0d want 32", n);
        end
        for (int s = 0; s < 32; s++) begin
            sel0 = 5'(s);
            sel1 = 5'(s ^ 5'd21);
            #1;
            vectors++;
            if (rd_a !== 64'h0 || rd_b !== 64'h0) begin
                miscompares++;
                $display("FAIL after_clear sel=%0d got a=%h b=%h want 0", s, rd_a, rd_b);
            end
        end
    endtask

    task automatic test_reg_read();
        logic [31:0] v3;
        v3 = $urandom | 32'h80000000;
        write_i = 1'b1;
        wsel = 5'd3;
        wdata = v3;
        tick();
        sel0 = 5'd7;
        wsel = 5'd7;
        wdata = 32'h12345678;
        tick();
        write_i = 1'b0;
        vectors++;
        if (rd_c[31:0] !== 32'h12345678) begin
            miscompares++;
            $display("FAIL reg_read_bypass got %h want 12345678", rd_c[31:0]);
        end
        sel0 = 5'd3;
        #1;
        vectors++;
        if (rd_c[31:0] !== 32'h12345678) begin
            miscompares++;
            $display("FAIL reg_read_hold got %h want 12345678", rd_c[31:0]);
        end
        tick();
        vectors++;
        if (rd_c[31:0] !== v3) begin
            miscompares++;
            $display("FAIL reg_read_new_sel got %h want %h", rd_c[31:0], v3);
        end
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 20; i < 26; i++) begin
            write_i = 1'b1;
            wsel = 5'(i);
            wdata = 32'hA500_0000 | 32'(i);
            tick();
        end
        write_i = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_clear_busy got %b want 0", busy_a);
        end
        for (int s = 0; s < 32; s++) begin
            sel0 = 5'(s);
            #1;
            vectors++;
            if (rd_a[31:0] !== 32'h0 || rd_b[31:0] !== 32'h0) begin
                miscompares++;
                $display("FAIL mid_clear_regs sel=%0d got a=%h b=%h want 0", s, rd_a[31:0], rd_b[31:0]);
            end
        end
        write_i = 1'b1;
        wsel = 5'd9;
        wdata = 32'hC0FFEE09;
        tick();
        write_i = 1'b0;
        sel0 = 5'd9;
        #1;
        vectors++;
        if (rd_a[31:0] !== 32'hC0FFEE09) begin
            miscompares++;
            $display("FAIL post_reset_write got %h want c0ffee09", rd_a[31:0]);
        end
    endtask

    task automatic test_random();
        logic [4:0] s;
        for (int c = 0; c < 400; c++) begin
            write_i = ($urandom % 3 != 0);
            wsel = 5'($urandom);
            wdata = $urandom;
            sel0 = ($urandom % 3 == 0) ? wsel : 5'($urandom);
            sel1 = ($urandom % 2 == 0) ? wsel : 5'($urandom);
            clear_req = ($urandom % 40 == 0);
            reset = ($urandom % 150 == 0);
            #1;
            vectors++;
            if (busy_a !== busy_m || busy_b !== busy_m || busy_c !== busy_m) begin
                miscompares++;
                $display("FAIL rand_busy cyc=%0d got %b%b%b want %b", c, busy_a, busy_b, busy_c, busy_m);
            end
            for (int p = 0; p < 2; p++) begin
                s = (p == 0) ? sel0 : sel1;
                vectors++;
                if (rd_a[p*32 +: 32] !== exp_read(s, 1'b1) || rd_b[p*32 +: 32] !== exp_read(s, 1'b0)
                    || rd_c[p*32 +: 32] !== rr_exp[p]) begin
                    miscompares++;
                    $display("FAIL rand_read cyc=%0d port=%0d sel=%0d got a=%h b=%h c=%h want a=%h b=%h c=%h",
                             c, p, s, rd_a[p*32 +: 32], rd_b[p*32 +: 32], rd_c[p*32 +: 32],
                             exp_read(s, 1'b1), exp_read(s, 1'b0), rr_exp[p]);
                end
            end
            tick();
        end
        reset = 1'b0;
        clear_req = 1'b0;
        write_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        z0_m = 32'h0;
        busy_m = 1'b0;
        cnt_m = 0;
        rr_exp[0] = 32'h0;
        rr_exp[1] = 32'h0;
        #2;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_reg_read();
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
